// File: rtl/nvdla_dbb_rsp_pkg.sv
// Shared definitions for the NVDLA DBB AXI responder.
//   state_e    : responder FSM states
//   BEAT_BYTES : bytes per data beat
//   BEAT_SHIFT : log2(BEAT_BYTES), byte address to word index shift
//   LEN_W      : width of the AXI burst length and beat counter
package nvdla_dbb_rsp_pkg;

    localparam int unsigned BEAT_BYTES = 8;
    localparam int unsigned BEAT_SHIFT = 3;
    localparam int unsigned LEN_W      = 4;

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StWrResp,
        StRdReq,
        StRdWait,
        StRdSend
    } state_e;

endpackage

// File: rtl/nvdla_dbb_axi_responder.sv
// AXI-style responder for the NVDLA DBB master port, backed by a single-port
// synchronous SRAM. One transaction is in flight at a time; reads and writes
// share the SRAM and are arbitrated round-robin when both address channels
// are valid in IDLE.
//
// Ports:
//   core_clk, rst            : clock and synchronous active-high reset
//   nvdla_core2dbb_aw_*      : write address channel (awsize ignored)
//   nvdla_core2dbb_w_*       : write data channel
//   nvdla_core2dbb_b_*       : write response channel
//   nvdla_core2dbb_ar_*      : read address channel (arsize ignored)
//   nvdla_core2dbb_r_*       : read data channel
//   mem_*                    : SRAM port; mem_rdata valid one cycle after a read mem_req
//   proto_err                : one-cycle pulse when wlast disagrees with the beat count
module nvdla_dbb_axi_responder
    import nvdla_dbb_rsp_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       ID_W      = 8,
    parameter int unsigned       MEM_AW    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                core_clk,
    input  logic                rst,

    input  logic                nvdla_core2dbb_aw_awvalid,
    output logic                nvdla_core2dbb_aw_awready,
    input  logic [ID_W-1:0]     nvdla_core2dbb_aw_awid,
    input  logic [LEN_W-1:0]    nvdla_core2dbb_aw_awlen,
    input  logic [2:0]          nvdla_core2dbb_aw_awsize,
    input  logic [ADDR_W-1:0]   nvdla_core2dbb_aw_awaddr,

    input  logic                nvdla_core2dbb_w_wvalid,
    output logic                nvdla_core2dbb_w_wready,
    input  logic [DATA_W-1:0]   nvdla_core2dbb_w_wdata,
    input  logic [DATA_W/8-1:0] nvdla_core2dbb_w_wstrb,
    input  logic                nvdla_core2dbb_w_wlast,

    output logic                nvdla_core2dbb_b_bvalid,
    input  logic                nvdla_core2dbb_b_bready,
    output logic [ID_W-1:0]     nvdla_core2dbb_b_bid,

    input  logic                nvdla_core2dbb_ar_arvalid,
    output logic                nvdla_core2dbb_ar_arready,
    input  logic [ID_W-1:0]     nvdla_core2dbb_ar_arid,
    input  logic [LEN_W-1:0]    nvdla_core2dbb_ar_arlen,
    input  logic [2:0]          nvdla_core2dbb_ar_arsize,
    input  logic [ADDR_W-1:0]   nvdla_core2dbb_ar_araddr,

    output logic                nvdla_core2dbb_r_rvalid,
    input  logic                nvdla_core2dbb_r_rready,
    output logic [ID_W-1:0]     nvdla_core2dbb_r_rid,
    output logic                nvdla_core2dbb_r_rlast,
    output logic [DATA_W-1:0]   nvdla_core2dbb_r_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                proto_err
);

    state_e              state_q;
    logic                pri_q;      // 0: write wins a tie, 1: read wins a tie
    logic [ID_W-1:0]     id_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    beat_q;
    logic [MEM_AW-1:0]   cur_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                is_idle;
    logic                grant_w;
    logic                grant_r;
    logic                aw_hs;
    logic                ar_hs;
    logic                w_hs;
    logic                last_beat;
    logic [ADDR_W-1:0]   aw_off;
    logic [ADDR_W-1:0]   ar_off;
    logic [MEM_AW-1:0]   aw_index;
    logic [MEM_AW-1:0]   ar_index;
    logic                unused_bits;

    // ------------------------------------------------------------------
    // Arbitration and address mapping
    // ------------------------------------------------------------------
    assign is_idle = (state_q == StIdle);
    assign grant_w = nvdla_core2dbb_aw_awvalid & (~nvdla_core2dbb_ar_arvalid | ~pri_q);
    assign grant_r = nvdla_core2dbb_ar_arvalid & ~grant_w;

    assign nvdla_core2dbb_aw_awready = is_idle & grant_w;
    assign nvdla_core2dbb_ar_arready = is_idle & grant_r;

    assign aw_hs = nvdla_core2dbb_aw_awvalid & nvdla_core2dbb_aw_awready;
    assign ar_hs = nvdla_core2dbb_ar_arvalid & nvdla_core2dbb_ar_arready;

    // Offsets wrap in ADDR_W bits; the word index then wraps modulo the SRAM depth.
    assign aw_off   = nvdla_core2dbb_aw_awaddr - BASE_ADDR;
    assign ar_off   = nvdla_core2dbb_ar_araddr - BASE_ADDR;
    assign aw_index = aw_off[BEAT_SHIFT +: MEM_AW];
    assign ar_index = ar_off[BEAT_SHIFT +: MEM_AW];

    // Size fields and the sub-beat/out-of-range address bits carry no meaning here.
    assign unused_bits = ^{nvdla_core2dbb_aw_awsize, nvdla_core2dbb_ar_arsize, aw_off, ar_off};

    assign last_beat = (beat_q == len_q);
    assign w_hs      = (state_q == StWrData) & nvdla_core2dbb_w_wvalid;

    // ------------------------------------------------------------------
    // Channel outputs, decoded from registered state
    // ------------------------------------------------------------------
    assign nvdla_core2dbb_w_wready = (state_q == StWrData);

    assign nvdla_core2dbb_b_bvalid = (state_q == StWrResp);
    assign nvdla_core2dbb_b_bid    = id_q;

    assign nvdla_core2dbb_r_rvalid = (state_q == StRdSend);
    assign nvdla_core2dbb_r_rid    = id_q;
    assign nvdla_core2dbb_r_rlast  = (state_q == StRdSend) & last_beat;
    assign nvdla_core2dbb_r_rdata  = rdata_q;

    // Beat count decides the burst end; wlast is only cross-checked.
    assign proto_err = w_hs & (nvdla_core2dbb_w_wlast != last_beat);

    // ------------------------------------------------------------------
    // SRAM port: writes go straight through in the W handshake cycle
    // ------------------------------------------------------------------
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = cur_q;
        mem_wdata = nvdla_core2dbb_w_wdata;
        mem_wstrb = '0;
        if (w_hs) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_wstrb = nvdla_core2dbb_w_wstrb;
        end else if (state_q == StRdReq) begin
            mem_req = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge core_clk) begin
        if (rst) begin
            state_q <= StIdle;
            pri_q   <= 1'b0;
            id_q    <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            cur_q   <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (aw_hs) begin
                        id_q    <= nvdla_core2dbb_aw_awid;
                        len_q   <= nvdla_core2dbb_aw_awlen;
                        cur_q   <= aw_index;
                        beat_q  <= '0;
                        pri_q   <= 1'b1;
                        state_q <= StWrData;
                    end else if (ar_hs) begin
                        id_q    <= nvdla_core2dbb_ar_arid;
                        len_q   <= nvdla_core2dbb_ar_arlen;
                        cur_q   <= ar_index;
                        beat_q  <= '0;
                        pri_q   <= 1'b0;
                        state_q <= StRdReq;
                    end
                end
                StWrData: begin
                    if (nvdla_core2dbb_w_wvalid) begin
                        cur_q  <= cur_q + MEM_AW'(1);
                        beat_q <= beat_q + LEN_W'(1);
                        if (last_beat) begin
                            state_q <= StWrResp;
                        end
                    end
                end
                StWrResp: begin
                    if (nvdla_core2dbb_b_bready) begin
                        state_q <= StIdle;
                    end
                end
                StRdReq: begin
                    state_q <= StRdWait;
                end
                StRdWait: begin
                    rdata_q <= mem_rdata;
                    state_q <= StRdSend;
                end
                StRdSend: begin
                    if (nvdla_core2dbb_r_rready) begin
                        if (last_beat) begin
                            state_q <= StIdle;
                        end else begin
                            cur_q   <= cur_q + MEM_AW'(1);
                            beat_q  <= beat_q + LEN_W'(1);
                            state_q <= StRdReq;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nvdla_dbb_axi_responder.sv
// Self-checking bench for nvdla_dbb_axi_responder: directed scenarios plus a
// randomized mix of writes, reads and tied requests, checked against a flat
// reference memory and a round-robin priority model.
module tb_nvdla_dbb_axi_responder;

    localparam int unsigned MEM_AW = 16;
    localparam int unsigned DEPTH  = 1 << MEM_AW;

    logic        core_clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [7:0]  awid, arid, bid, rid, wstrb, mem_wstrb;
    logic [3:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [63:0] awaddr, araddr, wdata, rdata, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, proto_err, mem_clr;
    logic [15:0] mem_addr;

    always #5 core_clk = ~core_clk;

    nvdla_dbb_axi_responder dut (
        .core_clk                  (core_clk),
        .rst                       (rst),
        .nvdla_core2dbb_aw_awvalid (awvalid),
        .nvdla_core2dbb_aw_awready (awready),
        .nvdla_core2dbb_aw_awid    (awid),
        .nvdla_core2dbb_aw_awlen   (awlen),
        .nvdla_core2dbb_aw_awsize  (awsize),
        .nvdla_core2dbb_aw_awaddr  (awaddr),
        .nvdla_core2dbb_w_wvalid   (wvalid),
        .nvdla_core2dbb_w_wready   (wready),
        .nvdla_core2dbb_w_wdata    (wdata),
        .nvdla_core2dbb_w_wstrb    (wstrb),
        .nvdla_core2dbb_w_wlast    (wlast),
        .nvdla_core2dbb_b_bvalid   (bvalid),
        .nvdla_core2dbb_b_bready   (bready),
        .nvdla_core2dbb_b_bid      (bid),
        .nvdla_core2dbb_ar_arvalid (arvalid),
        .nvdla_core2dbb_ar_arready (arready),
        .nvdla_core2dbb_ar_arid    (arid),
        .nvdla_core2dbb_ar_arlen   (arlen),
        .nvdla_core2dbb_ar_arsize  (arsize),
        .nvdla_core2dbb_ar_araddr  (araddr),
        .nvdla_core2dbb_r_rvalid   (rvalid),
        .nvdla_core2dbb_r_rready   (rready),
        .nvdla_core2dbb_r_rid      (rid),
        .nvdla_core2dbb_r_rlast    (rlast),
        .nvdla_core2dbb_r_rdata    (rdata),
        .mem_req                   (mem_req),
        .mem_we                    (mem_we),
        .mem_addr                  (mem_addr),
        .mem_wdata                 (mem_wdata),
        .mem_wstrb                 (mem_wstrb),
        .mem_rdata                 (mem_rdata),
        .proto_err                 (proto_err)
    );

    // Synchronous SRAM behind the DUT.
    logic [63:0] sram [DEPTH];
    always_ff @(posedge core_clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= '0;
        end else if (mem_req && mem_we) begin
            for (int b = 0; b < 8; b++)
                if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_req && !mem_we) mem_rdata <= sram[mem_addr];
    end

    // Reference model: expected memory contents and tie priority.
    logic [63:0] ref_mem [DEPTH];
    bit          pri_m;      // 0: next tie goes to write
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] widx(input logic [63:0] a);
        return a[18:3];
    endfunction

    task automatic wr_addr(input logic [63:0] addr, input logic [3:0] len, input logic [7:0] id);
        int n;
        awvalid = 1'b1; awaddr = addr; awlen = len; awid = id; awsize = 3'b011;
        n = 0;
        @(negedge core_clk);
        while (!awready && n < 50) begin @(negedge core_clk); n++; end
        check_eq("aw_accept", 64'(awready), 64'd1);
        check_eq("aw_excl_arready", 64'(arready), 64'd0);
        @(posedge core_clk); #1;
        awvalid = 1'b0;
        pri_m = 1'b1;
    endtask

    task automatic rd_addr(input logic [63:0] addr, input logic [3:0] len, input logic [7:0] id);
        int n;
        arvalid = 1'b1; araddr = addr; arlen = len; arid = id; arsize = 3'b011;
        n = 0;
        @(negedge core_clk);
        while (!arready && n < 50) begin @(negedge core_clk); n++; end
        check_eq("ar_accept", 64'(arready), 64'd1);
        check_eq("ar_excl_awready", 64'(awready), 64'd0);
        @(posedge core_clk); #1;
        arvalid = 1'b0;
        pri_m = 1'b0;
    endtask

    // fixed=1: data d0+beat with full strobes; else random data/strobes.
    // early_last>=0 puts wlast on that beat instead of the final one.
    task automatic wr_data(input logic [63:0] addr, input logic [3:0] len, input logic [7:0] id,
                           input logic [63:0] d0, input bit fixed, input int early_last,
                           input int bdelay);
        logic [15:0] a;
        logic [63:0] d;
        logic [7:0]  s;
        logic        wl;
        for (int b = 0; b <= int'(len); b++) begin
            a  = widx(addr) + 16'(b);
            d  = fixed ? d0 + 64'(b) : {$urandom, $urandom};
            s  = fixed ? 8'hFF : 8'($urandom);
            wl = (early_last >= 0) ? (b == early_last) : (b == int'(len));
            wvalid = 1'b1; wdata = d; wstrb = s; wlast = wl;
            @(negedge core_clk);
            check_eq("wready", 64'(wready), 64'd1);
            check_eq("wr_mem_req", 64'({mem_req, mem_we}), 64'd3);
            check_eq("wr_mem_addr", 64'(mem_addr), 64'(a));
            check_eq("wr_mem_wdata", mem_wdata, d);
            check_eq("wr_mem_wstrb", 64'(mem_wstrb), 64'(s));
            check_eq("proto_err", 64'(proto_err), 64'(wl != (b == int'(len))));
            for (int k = 0; k < 8; k++) if (s[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
            @(posedge core_clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        for (int k = 0; k < bdelay; k++) begin
            @(negedge core_clk);
            check_eq("bvalid_hold", 64'(bvalid), 64'd1);
            check_eq("bid_hold", 64'(bid), 64'(id));
            check_eq("b_no_mem_req", 64'(mem_req), 64'd0);
            @(posedge core_clk); #1;
        end
        bready = 1'b1;
        @(negedge core_clk);
        check_eq("bvalid", 64'(bvalid), 64'd1);
        check_eq("bid", 64'(bid), 64'(id));
        @(posedge core_clk); #1;
        bready = 1'b0;
    endtask

    // stall_beat: beat held with rready=0 for stall_n cycles.
    // abort_beat: beat on which rst is pulsed instead of accepting it.
    task automatic rd_data(input logic [63:0] addr, input logic [3:0] len, input logic [7:0] id,
                           input int stall_beat, input int stall_n, input int abort_beat);
        logic [15:0] a;
        logic [63:0] d0;
        logic        l0;
        int          lat;
        for (int b = 0; b <= int'(len); b++) begin
            a = widx(addr) + 16'(b);
            rready = (b != stall_beat);
            lat = 0;
            do begin
                @(negedge core_clk);
                lat++;
                if (lat == 1) begin
                    check_eq("rd_mem_req", 64'({mem_req, mem_we}), 64'd2);
                    check_eq("rd_mem_addr", 64'(mem_addr), 64'(a));
                end
            end while (!rvalid && lat < 20);
            if (!rvalid) begin
                check_eq("rvalid_timeout", 64'(rvalid), 64'd1);
                rready = 1'b0;
                return;
            end
            check_eq("r_latency", 64'(lat), 64'd3);
            if (b == abort_beat) begin
                rst = 1'b1;
                @(posedge core_clk); #1;
                rst = 1'b0; rready = 1'b0; pri_m = 1'b0;
                @(negedge core_clk);
                check_eq("abort_rvalid", 64'(rvalid), 64'd0);
                check_eq("abort_mem_req", 64'(mem_req), 64'd0);
                check_eq("abort_bvalid", 64'(bvalid), 64'd0);
                @(posedge core_clk); #1;
                return;
            end
            if (b == stall_beat) begin
                d0 = rdata; l0 = rlast;
                for (int k = 0; k < stall_n; k++) begin
                    @(posedge core_clk); #1;
                    @(negedge core_clk);
                    check_eq("stall_rvalid", 64'(rvalid), 64'd1);
                    check_eq("stall_rdata", rdata, d0);
                    check_eq("stall_rlast", 64'(rlast), 64'(l0));
                    check_eq("stall_mem_req", 64'(mem_req), 64'd0);
                end
                rready = 1'b1;
            end
            check_eq("rdata", rdata, ref_mem[a]);
            check_eq("rlast", 64'(rlast), 64'(b == int'(len)));
            check_eq("rid", 64'(rid), 64'(id));
            @(posedge core_clk); #1;
        end
        rready = 1'b0;
    endtask

    // Both address channels valid together; the model picks the winner.
    task automatic tie(input logic [63:0] wa, input logic [3:0] wl, input logic [7:0] wid,
                       input logic [63:0] ra, input logic [3:0] rl, input logic [7:0] rdid);
        bit exp_w;
        awvalid = 1'b1; awaddr = wa; awlen = wl; awid = wid; awsize = 3'b011;
        arvalid = 1'b1; araddr = ra; arlen = rl; arid = rdid; arsize = 3'b011;
        #1;
        exp_w = (pri_m == 1'b0);
        check_eq("tie_awready", 64'(awready), 64'(exp_w));
        check_eq("tie_arready", 64'(arready), 64'(!exp_w));
        if (exp_w) begin
            wr_addr(wa, wl, wid); wr_data(wa, wl, wid, 64'd0, 1'b0, -1, 0);
            rd_addr(ra, rl, rdid); rd_data(ra, rl, rdid, -1, 0, -1);
        end else begin
            rd_addr(ra, rl, rdid); rd_data(ra, rl, rdid, -1, 0, -1);
            wr_addr(wa, wl, wid); wr_data(wa, wl, wid, 64'd0, 1'b0, -1, 0);
        end
    endtask

    initial begin
        logic [63:0] a, a2;
        logic [3:0]  l;
        int          sel;
        rst = 1'b1; mem_clr = 1'b1; pri_m = 1'b0;
        awvalid = 0; awid = 0; awlen = 0; awsize = 3'b011; awaddr = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; arid = 0; arlen = 0; arsize = 3'b011; araddr = 0; rready = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        repeat (3) @(posedge core_clk);
        #1;
        rst = 1'b0; mem_clr = 1'b0;

        @(negedge core_clk);
        check_eq("rst_ready", 64'({awready, arready, wready}), 64'd0);
        check_eq("rst_valid", 64'({bvalid, rvalid, rlast}), 64'd0);
        check_eq("rst_ids", 64'({bid, rid}), 64'd0);
        check_eq("rst_rdata", rdata, 64'd0);
        check_eq("rst_mem", 64'({mem_req, mem_we, proto_err}), 64'd0);
        @(posedge core_clk); #1;

        // Tie straight out of reset: write first.
        tie(64'h200, 4'd1, 8'h11, 64'h200, 4'd1, 8'h22);
        wr_addr(64'h40, 4'd0, 8'h5A);
        wr_data(64'h40, 4'd0, 8'h5A, 64'h1122334455667788, 1'b1, -1, 0);
        // Last accept was a write, so this tie goes to read.
        tie(64'h300, 4'd2, 8'h33, 64'h40, 4'd0, 8'h44);
        tie(64'h380, 4'd0, 8'h55, 64'h300, 4'd2, 8'h66);

        // Burst write and readback.
        wr_addr(64'h100, 4'd3, 8'h01);
        wr_data(64'h100, 4'd3, 8'h01, 64'd1, 1'b1, -1, 2);
        rd_addr(64'h100, 4'd3, 8'h03);
        rd_data(64'h100, 4'd3, 8'h03, -1, 0, -1);

        // Backpressure on beat 2.
        rd_addr(64'h100, 4'd3, 8'h07);
        rd_data(64'h100, 4'd3, 8'h07, 1, 5, -1);

        // wlast on the first of two beats.
        wr_addr(64'h500, 4'd1, 8'h09);
        wr_data(64'h500, 4'd1, 8'h09, 64'hA0, 1'b1, 0, 0);

        // Burst crossing the top of the SRAM, from an address with stray low/high bits.
        a = 64'hF000_0000_0007_FFFD;
        wr_addr(a, 4'd1, 8'h0A);
        wr_data(a, 4'd1, 8'h0A, 64'hBEEF, 1'b1, -1, 1);
        rd_addr(64'h7FFF8, 4'd1, 8'h0B);
        rd_data(64'h7FFF8, 4'd1, 8'h0B, -1, 0, -1);

        // Randomized mix.
        for (int t = 0; t < 40; t++) begin
            a   = {$urandom, $urandom};
            a2  = (t % 2 == 0) ? a : {32'($urandom), 13'($urandom), 19'($urandom_range(0, 1023))};
            l   = 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                wr_addr(a, l, 8'($urandom));
                wr_data(a, l, awid, 64'd0, 1'b0, -1, $urandom_range(0, 2));
                rd_addr(a, l, 8'($urandom));
                rd_data(a, l, arid, $urandom_range(0, 15), $urandom_range(1, 3), -1);
            end else if (sel == 1) begin
                rd_addr(a2, l, 8'($urandom));
                rd_data(a2, l, arid, -1, 0, -1);
            end else begin
                tie(a, l, 8'($urandom), a2, 4'($urandom_range(0, 15)), 8'($urandom));
            end
        end

        // Reset in the middle of a long read, then a clean read.
        wr_addr(64'h800, 4'd7, 8'h0C);
        wr_data(64'h800, 4'd7, 8'h0C, 64'h1000, 1'b1, -1, 0);
        rd_addr(64'h800, 4'd7, 8'h0D);
        rd_data(64'h800, 4'd7, 8'h0D, -1, 0, 1);
        tie(64'h900, 4'd0, 8'h0E, 64'h800, 4'd7, 8'h0F);
        rd_addr(64'h800, 4'd7, 8'h10);
        rd_data(64'h800, 4'd7, 8'h10, -1, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
